// File: rtl/hazard_stall_controller.sv
// Purpose : pipeline interlock sequencer (load-use bubble, data-memory wait freeze, mispredict squash).
// Latency : controls are combinational from state+inputs (same cycle); state/counters update on clk.
// Backpr. : data-memory wait freezes the whole pipe until dmem_ready; a wait past MEM_TIMEOUT locks in ERR.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ID_rs1/ID_rs2/ID_uses_rs2   source registers of the instruction in ID
//   EX_MemRead/EX_RegWriteAddr  load flag and destination of the instruction in EX
//   MEM_MemAccess, dmem_ready   data-memory access present in MEM, and its completion
//   EX_mispredict               branch in EX resolved mispredicted
//   dmem_req                    data-memory request valid
//   pc_hold, *_hold             pipeline register / PC keeps its value
//   IF_ID_flush, *_bubble       pipeline register loads a NOP
//   mem_timeout                 sticky data-memory timeout flag
//   stall_cycles                saturating count of cycles with pc_hold asserted

module hazard_stall_controller #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_uses_rs2,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_RegWriteAddr,
    input  logic             MEM_MemAccess,
    input  logic             dmem_ready,
    input  logic             EX_mispredict,
    output logic             dmem_req,
    output logic             pc_hold,
    output logic             IF_ID_hold,
    output logic             IF_ID_flush,
    output logic             ID_EX_hold,
    output logic             ID_EX_bubble,
    output logic             EX_MEM_hold,
    output logic             MEM_WB_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    // Wait counter must be able to hold MEM_TIMEOUT itself.
    localparam int unsigned              WCNT_W      = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0]        TIMEOUT_VAL = WCNT_W'(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0]        WCNT_ONE    = WCNT_W'(1);
    localparam logic [CNT_W-1:0]         CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]         CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    state_t             r_state;
    logic [WCNT_W-1:0]  r_wait_cnt;
    logic               r_mem_timeout;
    logic [CNT_W-1:0]   r_stall_cycles;

    // Hazard detection
    logic w_mem_stall;
    logic w_rd_nz;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;

    assign w_mem_stall = MEM_MemAccess && !dmem_ready;
    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign w_rd_nz     = (EX_RegWriteAddr != 5'd0);
    assign w_rs1_hit   = (EX_RegWriteAddr == ID_rs1);
    assign w_rs2_hit   = ID_uses_rs2 && (EX_RegWriteAddr == ID_rs2);
    assign w_load_use  = EX_MemRead && w_rd_nz && (w_rs1_hit || w_rs2_hit);

    // Control class decode: freeze, squash or load-use stall (mutually exclusive).
    logic              w_freeze;
    logic              w_squash;
    logic              w_lu_stall;
    state_t            w_state_nxt;
    logic [WCNT_W-1:0] w_wait_nxt;
    logic              w_timeout_set;

    always_comb begin
        w_freeze      = 1'b0;
        w_squash      = 1'b0;
        w_lu_stall    = 1'b0;
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_timeout_set = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_mem_stall) begin
                    w_freeze    = 1'b1;
                    w_state_nxt = ST_MEM_WAIT;
                    w_wait_nxt  = WCNT_ONE;
                end else if (EX_mispredict) begin
                    // The ID instruction is squashed, so its load-use hazard is moot.
                    w_squash = 1'b1;
                end else if (w_load_use) begin
                    w_lu_stall = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    // Access completes: apply whatever EX/ID hazard was held during the wait.
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                    if (EX_mispredict) begin
                        w_squash = 1'b1;
                    end else if (w_load_use) begin
                        w_lu_stall = 1'b1;
                    end
                end else begin
                    w_freeze = 1'b1;
                    if (r_wait_cnt == TIMEOUT_VAL) begin
                        w_state_nxt   = ST_ERR;
                        w_timeout_set = 1'b1;
                    end else begin
                        w_wait_nxt = r_wait_cnt + WCNT_ONE;
                    end
                end
            end

            ST_ERR: begin
                w_freeze = 1'b1;
            end

            default: begin
                // Unreachable encoding: park the pipe and lock up like a timeout.
                w_freeze    = 1'b1;
                w_state_nxt = ST_ERR;
            end
        endcase
    end

    // Ungated PC hold drives the stall counter; flops are in reset anyway while rst_n is low.
    logic w_pc_hold_raw;
    assign w_pc_hold_raw = w_freeze || w_lu_stall;

    // Outputs are forced low during reset so the combinational input paths
    // cannot hold the pipe while the controller itself is being reset.
    assign pc_hold       = rst_n && w_pc_hold_raw;
    assign IF_ID_hold    = rst_n && (w_freeze || w_lu_stall);
    assign IF_ID_flush   = rst_n && w_squash;
    assign ID_EX_hold    = rst_n && w_freeze;
    assign ID_EX_bubble  = rst_n && (w_squash || w_lu_stall);
    assign EX_MEM_hold   = rst_n && w_freeze;
    assign MEM_WB_bubble = rst_n && w_freeze;
    assign dmem_req      = rst_n && MEM_MemAccess && (r_state != ST_ERR);

    assign mem_timeout   = r_mem_timeout;
    assign stall_cycles  = r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_RUN;
            r_wait_cnt     <= '0;
            r_mem_timeout  <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_timeout_set) begin
                r_mem_timeout <= 1'b1;
            end
            if (w_pc_hold_raw && (r_stall_cycles != CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + CNT_ONE;
            end
        end
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central interlock sequencer for the 5-stage RV32I pipeline. It works alongside the forwarding unit.
- Covers the hazards forwarding cannot resolve:
  - load-use dependencies, which get a one-cycle bubble;
  - multi-cycle data-memory accesses, which freeze the pipeline until a ready handshake;
  - branch mispredict squashes.
- Drives hold, bubble and flush controls to every pipeline register and the PC.
- Provides a data-memory timeout watchdog and a stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 255: number of consecutive wait cycles in MEM_WAIT before a timeout is declared (minimum 1).
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ID_rs1  in  5  rs1 of the instruction in ID
- ID_rs2  in  5  rs2 of the instruction in ID
- ID_uses_rs2  in  1  ID instruction reads rs2
- EX_MemRead  in  1  instruction in EX is a load
- EX_RegWriteAddr  in  5  rd of the instruction in EX
- MEM_MemAccess  in  1  load or store present in MEM
- dmem_ready  in  1  data memory completes the current access this cycle
- EX_mispredict  in  1  branch resolved mispredicted in EX
- dmem_req  out  1  data-memory request valid
- pc_hold  out  1  PC keeps its value
- IF_ID_hold  out  1  IF/ID register keeps its value
- IF_ID_flush  out  1  IF/ID register loads a NOP
- ID_EX_hold  out  1  ID/EX register keeps its value
- ID_EX_bubble  out  1  ID/EX register loads a NOP
- EX_MEM_hold  out  1  EX/MEM register keeps its value
- MEM_WB_bubble  out  1  MEM/WB register loads a NOP
- mem_timeout  out  1  sticky data-memory timeout flag
- stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
Reset (async, rst_n=0):
- state=RUN, wait counter=0, mem_timeout=0, stall_cycles=0.
- All hold, flush and bubble outputs are 0; dmem_req=0.
- A reset asserted mid-wait aborts the wait immediately; the controller does not wait for dmem_ready.

State machine (state register only; all control outputs are combinational from state and inputs, same cycle):

States are RUN, MEM_WAIT and ERR.

Definitions:
- mem_stall = MEM_MemAccess && !dmem_ready
- load_use = EX_MemRead && EX_RegWriteAddr!=0 && (EX_RegWriteAddr==ID_rs1 || (ID_uses_rs2 && EX_RegWriteAddr==ID_rs2))
- freeze = pc_hold, IF_ID_hold, ID_EX_hold, EX_MEM_hold and MEM_WB_bubble all 1

RUN, evaluated in strict priority order:
1. mem_stall: freeze; next state MEM_WAIT; wait counter←1.
2. EX_mispredict: IF_ID_flush=1 and ID_EX_bubble=1. load_use is ignored because the ID instruction is squashed.
3. load_use: pc_hold=1, IF_ID_hold=1, ID_EX_bubble=1 for exactly that cycle. After the bubble the load is in MEM, and forwarding resolves the dependency next cycle.
4. Otherwise all controls are 0.

MEM_WAIT:
- dmem_ready=1: controls are evaluated exactly as in RUN with mem_stall=0, so a pending mispredict or load-use is applied in this cycle. Next state RUN; wait counter←0.
- dmem_ready=0: freeze.
  - If wait counter==MEM_TIMEOUT: next state ERR and mem_timeout←1.
  - Otherwise the wait counter increments.
- Inputs from the frozen stages are stable during a wait, so EX_mispredict is not lost.

ERR:
- freeze permanently; dmem_req=0; mem_timeout stays 1.
- Exit is by reset only.

dmem_req:
- dmem_req = MEM_MemAccess whenever state≠ERR, and is held through MEM_WAIT.
- dmem_req drops only in the cycle dmem_ready is sampled high when MEM_MemAccess deasserts next.

stall_cycles:
- Increments by 1 on each clock edge where pc_hold=1.
- Saturates at 2^CNT_W−1 with no wrap.

Boundary conditions:
- A load with rd=x0 never triggers load_use.
- A zero-wait access (dmem_ready=1 in the first cycle) causes no stall and no state change.
- A single-cycle wait costs 1 frozen cycle.
- A simultaneous mispredict and load_use in RUN results in a flush only; no hold is asserted.

Test Plan:
1. Load-use:
   - Stimulus: EX_MemRead=1, EX_RegWriteAddr=5, ID_rs1=5 for one cycle.
   - Required: pc_hold, IF_ID_hold and ID_EX_bubble all =1 for 1 cycle; stall_cycles=1; the rd=0 variant gives no stall.
2. rs2 gating:
   - Stimulus: ID_rs2=5 with ID_uses_rs2=0, then with ID_uses_rs2=1.
   - Required: no stall for the first case, a one-cycle stall for the second.
3. Memory wait:
   - Stimulus: MEM_MemAccess=1 with dmem_ready held low for 3 cycles, then high.
   - Required: freeze for 3 cycles; dmem_req=1 throughout; return to RUN; stall_cycles=3.
4. Mispredict during wait:
   - Stimulus: EX_mispredict=1 throughout a 2-cycle wait.
   - Required: IF_ID_flush is 0 during the wait, then 1 in the dmem_ready cycle, together with ID_EX_bubble=1.
5. Timeout:
   - Stimulus: MEM_TIMEOUT=4, dmem_ready never asserted.
   - Required: ERR entered after 5 frozen cycles; mem_timeout=1 sticky; dmem_req=0; freeze persists until rst_n.
6. Async reset mid-wait plus saturation:
   - Stimulus: assert rst_n=0 in MEM_WAIT; separately run with CNT_W=3 and 10 stall cycles.
   - Required: all outputs 0 immediately without a clock edge; stall_cycles saturates at 7.
